// File: rtl/mux21_2bits_arbiter_pkg.sv
// Shared constants for the 2-bit 2:1 mux arbiter.
// State encodings and the default hold limit.
package mux21_2bits_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE   = 2'b00;
    localparam logic [1:0] ARB_GRANT0 = 2'b01;
    localparam logic [1:0] ARB_GRANT1 = 2'b10;

    localparam int DEF_MAX_HOLD = 4;

endpackage

// File: rtl/arb_hold_counter.sv
// Hold counter for the arbiter: clear, enable, async reset.
// terminal flags the last contended cycle before a forced switch.
module arb_hold_counter #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 3
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             terminal
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(MAX_HOLD - 1);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign terminal = (cnt == TERM);

endmodule

// File: rtl/mux21_2bits_arbiter.sv
// Round-robin arbiter driving the shared 2-bit 2:1 mux datapath.
// FSM, round-robin pointer and registered mux outputs.
module mux21_2bits_arbiter
    import mux21_2bits_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int CNT_W    = 3
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       req0,
    input  logic [1:0] data_in0,
    input  logic       req1,
    input  logic [1:0] data_in1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       selector,
    output logic [1:0] data_out,
    output logic       valid_out
);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             last_gnt;
    logic [CNT_W-1:0] hold_cnt;
    logic             hold_term;
    logic             cnt_en;
    logic             cnt_clr;
    logic             xfer0;
    logic             xfer1;

    assign xfer0 = (state == ARB_GRANT0) && req0;
    assign xfer1 = (state == ARB_GRANT1) && req1;

    // Only a holder that keeps requesting under contention accrues hold time
    assign cnt_en  = (xfer0 || xfer1) && req0 && req1;
    assign cnt_clr = !cnt_en || (state_nxt != state);

    arb_hold_counter #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (CNT_W)
    ) u_hold (
        .clk      (clk),
        .reset_L  (reset_L),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .cnt      (hold_cnt),
        .terminal (hold_term)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            ARB_IDLE: begin
                if (req0 && req1)
                    state_nxt = last_gnt ? ARB_GRANT0 : ARB_GRANT1;
                else if (req0)
                    state_nxt = ARB_GRANT0;
                else if (req1)
                    state_nxt = ARB_GRANT1;
            end
            ARB_GRANT0: begin
                if (!req0)
                    state_nxt = req1 ? ARB_GRANT1 : ARB_IDLE;
                else if (req1 && hold_term)
                    state_nxt = ARB_GRANT1;
            end
            ARB_GRANT1: begin
                if (!req1)
                    state_nxt = req0 ? ARB_GRANT0 : ARB_IDLE;
                else if (req0 && hold_term)
                    state_nxt = ARB_GRANT0;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state    <= ARB_IDLE;
            last_gnt <= 1'b1;
            selector <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state && state_nxt != ARB_IDLE)
                last_gnt <= (state_nxt == ARB_GRANT1);
            // Selector keeps its last source while idle
            if (state_nxt == ARB_GRANT0)
                selector <= 1'b0;
            else if (state_nxt == ARB_GRANT1)
                selector <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_out  <= 2'b00;
            valid_out <= 1'b0;
        end else begin
            valid_out <= xfer0 || xfer1;
            if (xfer0)
                data_out <= data_in0;
            else if (xfer1)
                data_out <= data_in1;
        end
    end

    assign gnt0 = (state == ARB_GRANT0);
    assign gnt1 = (state == ARB_GRANT1);

endmodule

// File: tb/tb_mux21_2bits_arbiter.sv
// Testbench for mux21_2bits_arbiter, MAX_HOLD=4 and MAX_HOLD=1 side by side.
// Outputs are checked against a transfer-level round-robin model.
module tb_mux21_2bits_arbiter;

    logic       clk;
    logic       reset_L;
    logic       req0;
    logic       req1;
    logic [1:0] data_in0;
    logic [1:0] data_in1;

    logic       g0_a, g1_a, sel_a, val_a;
    logic       g0_b, g1_b, sel_b, val_b;
    logic [1:0] dat_a, dat_b;
    logic [5:0] obs [2];

    int nvec = 0;
    int nmiss = 0;

    int         owner  [2];
    int         last   [2];
    int         streak [2];
    int         hold   [2] = '{4, 1};
    logic       sel_m  [2];
    logic [1:0] dat_m  [2];
    logic       val_m  [2];

    mux21_2bits_arbiter #(.MAX_HOLD(4), .CNT_W(3)) u_h4 (
        .clk(clk), .reset_L(reset_L),
        .req0(req0), .data_in0(data_in0),
        .req1(req1), .data_in1(data_in1),
        .gnt0(g0_a), .gnt1(g1_a), .selector(sel_a),
        .data_out(dat_a), .valid_out(val_a)
    );

    mux21_2bits_arbiter #(.MAX_HOLD(1), .CNT_W(3)) u_h1 (
        .clk(clk), .reset_L(reset_L),
        .req0(req0), .data_in0(data_in0),
        .req1(req1), .data_in1(data_in1),
        .gnt0(g0_b), .gnt1(g1_b), .selector(sel_b),
        .data_out(dat_b), .valid_out(val_b)
    );

    assign obs[0] = {g0_a, g1_a, sel_a, dat_a, val_a};
    assign obs[1] = {g0_b, g1_b, sel_b, dat_b, val_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            owner[d]  = -1;
            last[d]   = 1;
            streak[d] = 0;
            sel_m[d]  = 1'b0;
            dat_m[d]  = 2'b00;
            val_m[d]  = 1'b0;
        end
    endtask

    // One clock edge as seen by a transfer-level arbiter
    task automatic model_step(input logic r0, input logic r1,
                              input logic [1:0] a, input logic [1:0] b);
        logic       rq [2];
        logic [1:0] dd [2];
        int nxt;
        rq[0] = r0; rq[1] = r1;
        dd[0] = a;  dd[1] = b;
        for (int d = 0; d < 2; d++) begin
            if (owner[d] >= 0 && rq[owner[d]]) begin
                val_m[d] = 1'b1;
                dat_m[d] = dd[owner[d]];
            end else begin
                val_m[d] = 1'b0;
            end
            nxt = owner[d];
            if (owner[d] < 0) begin
                if (r0 && r1)  nxt = 1 - last[d];
                else if (r0)   nxt = 0;
                else if (r1)   nxt = 1;
            end else if (!rq[owner[d]]) begin
                nxt = rq[1 - owner[d]] ? 1 - owner[d] : -1;
            end else if (rq[1 - owner[d]]) begin
                streak[d]++;
                if (streak[d] == hold[d]) nxt = 1 - owner[d];
            end else begin
                streak[d] = 0;
            end
            if (nxt != owner[d]) begin
                streak[d] = 0;
                if (nxt >= 0) last[d] = nxt;
            end
            owner[d] = nxt;
            if (owner[d] == 0) sel_m[d] = 1'b0;
            if (owner[d] == 1) sel_m[d] = 1'b1;
        end
    endtask

    function automatic logic [5:0] exp_v(input int d);
        return {owner[d] == 0, owner[d] == 1, sel_m[d], dat_m[d], val_m[d]};
    endfunction

    task automatic step(input logic r0, input logic r1,
                        input logic [1:0] a, input logic [1:0] b);
        req0 = r0; req1 = r1;
        data_in0 = a; data_in1 = b;
        @(posedge clk);
        model_step(r0, r1, a, b);
        #1;
    endtask

    task automatic test_reset();
        reset_L = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        data_in0 = 2'b00; data_in1 = 2'b00;
        model_reset();
        #12;
        for (int d = 0; d < 2; d++) begin
            nvec++;
            if (obs[d] !== 6'b0) begin
                nmiss++;
                $display("FAIL reset_init dut%0d got %b want %b", d, obs[d], 6'b0);
            end
        end
        @(posedge clk); #1;
        reset_L = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'b00, 2'b10);
        // Mid-grant, valid high: reset must clear outputs with no edge
        #3;
        reset_L = 1'b0;
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            nvec++;
            if (obs[d] !== 6'b0) begin
                nmiss++;
                $display("FAIL reset_async dut%0d got %b want %b", d, obs[d], 6'b0);
            end
        end
        @(posedge clk); #1;
        reset_L = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 2'b01, 2'b10);
            for (int d = 0; d < 2; d++) begin
                nvec++;
                if (obs[d] !== exp_v(d)) begin
                    nmiss++;
                    $display("FAIL reset_tie dut%0d cyc%0d got %b want %b",
                             d, i, obs[d], exp_v(d));
                end
            end
        end
        nvec++;
        if (i_first_gnt() !== 1'b1) begin
            nmiss++;
            $display("FAIL reset_first_gnt0 got %b want 1", i_first_gnt());
        end
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 2'b00, 2'b00);
    endtask

    function automatic logic i_first_gnt();
        return g0_a;
    endfunction

    task automatic test_single();
        logic [1:0] seq [5] = '{2'b01, 2'b01, 2'b10, 2'b11, 2'b00};
        logic       rq  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            step(rq[i], 1'b0, seq[i], 2'b00);
            for (int d = 0; d < 2; d++) begin
                nvec++;
                if (obs[d] !== exp_v(d)) begin
                    nmiss++;
                    $display("FAIL single dut%0d cyc%0d got %b want %b",
                             d, i, obs[d], exp_v(d));
                end
            end
        end
        step(1'b0, 1'b0, 2'b00, 2'b00);
    endtask

    task automatic test_contention();
        for (int i = 0; i < 18; i++) begin
            step(1'b1, 1'b1, 2'b00, 2'b11);
            for (int d = 0; d < 2; d++) begin
                nvec++;
                if (obs[d] !== exp_v(d)) begin
                    nmiss++;
                    $display("FAIL contention dut%0d cyc%0d got %b want %b",
                             d, i, obs[d], exp_v(d));
                end
            end
        end
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 2'b00, 2'b00);
    endtask

    task automatic test_handover();
        logic r0s [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic r1s [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            step(r0s[i], r1s[i], 2'b10, 2'b01);
            for (int d = 0; d < 2; d++) begin
                nvec++;
                if (obs[d] !== exp_v(d)) begin
                    nmiss++;
                    $display("FAIL handover dut%0d cyc%0d got %b want %b",
                             d, i, obs[d], exp_v(d));
                end
            end
        end
    endtask

    task automatic test_uncontended();
        for (int i = 0; i < 30; i++) begin
            step(i >= 20, 1'b1, 2'(i), 2'(i + 1));
            nvec++;
            if (i < 20 && u_h4.hold_cnt !== 3'd0) begin
                nmiss++;
                $display("FAIL uncont_cnt cyc%0d got %0d want 0", i, u_h4.hold_cnt);
            end
            for (int d = 0; d < 2; d++) begin
                nvec++;
                if (obs[d] !== exp_v(d)) begin
                    nmiss++;
                    $display("FAIL uncontended dut%0d cyc%0d got %b want %b",
                             d, i, obs[d], exp_v(d));
                end
            end
        end
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 2'b00, 2'b00);
    endtask

    task automatic test_random();
        logic r0, r1;
        for (int i = 0; i < 300; i++) begin
            r0 = ($urandom_range(0, 3) != 0);
            r1 = ($urandom_range(0, 3) != 0);
            step(r0, r1, 2'($urandom), 2'($urandom));
            for (int d = 0; d < 2; d++) begin
                nvec++;
                if (obs[d] !== exp_v(d)) begin
                    nmiss++;
                    $display("FAIL random dut%0d cyc%0d got %b want %b",
                             d, i, obs[d], exp_v(d));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_handover();
        test_uncontended();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end

endmodule
